fp_add_arbiter: RTL and testbench
=================================

Name: fp_add_arbiter

Overview:
- Shares one combinational single-precision adder (existing module `adder`, 32-bit a/b in, 32-bit out) between NUM_REQ requesters, such as the Jacobi rotation units.
- Round-robin arbitration with a valid/ready handshake on each request port.
- Optional subtract: the block flips the sign of operand b before the adder.
- One registered, tagged result port with backpressure; feeds the rotation-update datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- IDW, $clog2(NUM_REQ), width of the requester tag.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  per-requester grant/accept, at most one bit high.
- req_a  in  NUM_REQ*32  operand a, requester i at [32*i+31:32*i].
- req_b  in  NUM_REQ*32  operand b, same packing.
- req_sub  in  NUM_REQ  1 = compute a-b (b[31] inverted), 0 = a+b.
- rsp_valid  out  1  result register holds a valid result.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  32  IEEE-754 single result from `adder`.
- rsp_id  out  IDW  index of the requester that produced rsp_data.
- op_count  out  CNT_W  completed-response counter.

Behaviour:
- Reset (async, rst_n=0): rsp_valid=0, rsp_data=0, rsp_id=0, op_count=0, rr_ptr=0. req_ready=0 while in reset.
- can_issue = !rsp_valid || rsp_ready (combinational).
- Arbitration: when can_issue, grant g = first index i with req_valid[i], scanning rr_ptr, rr_ptr+1, … and wrapping modulo NUM_REQ.
  - req_ready[g]=1, all other bits 0.
  - No grant when !can_issue or no req_valid; then req_ready=0.
  - req_ready may depend combinationally on req_valid and rsp_ready. No requester may wait on req_ready before asserting valid.
- Transfer occurs when req_valid[g] && req_ready[g]. Requesters hold valid, a, b and sub stable until transfer; the block never drops a request.
- Datapath:
  - adder.a = req_a[g].
  - adder.b = {req_b[g][31]^req_sub[g], req_b[g][30:0]}.
- On transfer, at the next rising edge: rsp_data<=adder.out, rsp_id<=g, rsp_valid<=1, rr_ptr<=(g==NUM_REQ-1)?0:g+1.
- Latency: exactly 1 cycle from transfer to rsp_valid. Throughput: 1 op/cycle while rsp_ready=1.
- No transfer and rsp_ready=1: rsp_valid<=0, rsp_data/rsp_id hold.
- Backpressure: rsp_valid=1 and rsp_ready=0 means rsp_data, rsp_id and rsp_valid hold, and no grant is given.
- Simultaneous rsp accept and new transfer in the same cycle: the register is overwritten with the new result and rsp_valid stays 1 (no bubble).
- op_count increments by 1 on every rsp_valid && rsp_ready. It wraps from 2^CNT_W-1 to 0 with no saturation.
- rr_ptr changes only on a transfer. Idle cycles do not rotate priority.
- Reset mid-operation: any pending result is discarded. Requesters still holding valid are re-arbitrated from index 0 after reset release.
- Arithmetic is entirely that of `adder`. The block does no rounding, special-case or denormal handling of its own.
- Requesters with req_valid=0 never get a grant, even when rr_ptr points to them.

Decomposition:
- Package fp_arb_pkg: FP_W=32, default NUM_REQ, and a function for the operand slice of requester i.
- Sub-module rr_arbiter: parameter NUM_REQ; inputs req vector, rr_ptr and enable; outputs one-hot grant and encoded index. Purely combinational.
- Top level holds rr_ptr, the result register, op_count, the operand mux and the `adder` instance.

Test Plan:
1. Single requester 0: a=0x3F800000, b=0x40000000, sub=0, rsp_ready=1. Required: req_ready[0] in the same cycle; next cycle rsp_valid=1, rsp_data=0x40400000, rsp_id=0; op_count=1 after accept.
2. Subtract on requester 2: a=0x40400000, b=0x3F800000, sub=1. Required: rsp_data=0x40000000, rsp_id=2.
3. All 4 requesters valid continuously, rsp_ready=1, from reset. Required: grant order 0,1,2,3,0,1 with one result per cycle. Each requester uses a=0x3F800000, b=0x3F800000 → rsp_data=0x40000000.
4. Backpressure: rsp_ready=0 for 3 cycles with a result held. Required: rsp_data/rsp_id stable, req_ready all 0. On rsp_ready=1, the next grant is issued that same cycle with no bubble.
5. Reset asserted mid-stream (rsp_valid=1, rr_ptr=2). Required: rsp_valid, rsp_id, rsp_data and op_count drop to 0 immediately, without waiting for a clock. After release, requester 0 wins first even if requesters 2 and 3 are valid.
6. op_count wrap: preload by running 65536 accepted ops with CNT_W=16. Required: op_count returns to 0 and continues to 1.

Source files
------------

// File: rtl/fp_arb_pkg.sv
// rtl/fp_arb_pkg.sv - shared constants and operand-slice helper for the FP adder arbiter
package fp_arb_pkg;

  localparam int FP_W        = 32;
  localparam int DEF_NUM_REQ = 4;

  function automatic int unsigned op_lsb(input int unsigned idx);
    return idx * FP_W;
  endfunction

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - combinational IEEE-754 single-precision adder, round to nearest even
module adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out
);

  logic        sx, sy, rnd;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic [9:0]  ex, ey, dexp, er;
  logic [23:0] mx, my;
  logic [27:0] xe, yf, ys, s, mask;
  logic [24:0] m;

  always_comb begin
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);

    // x is the operand of larger magnitude; denormals use exponent 1 with no hidden bit
    if (a[30:0] >= b[30:0]) begin
      sx = a[31];
      sy = b[31];
      ex = {2'b00, (a[30:23] == 8'd0) ? 8'd1 : a[30:23]};
      ey = {2'b00, (b[30:23] == 8'd0) ? 8'd1 : b[30:23]};
      mx = {a[30:23] != 8'd0, a[22:0]};
      my = {b[30:23] != 8'd0, b[22:0]};
    end else begin
      sx = b[31];
      sy = a[31];
      ex = {2'b00, (b[30:23] == 8'd0) ? 8'd1 : b[30:23]};
      ey = {2'b00, (a[30:23] == 8'd0) ? 8'd1 : a[30:23]};
      mx = {b[30:23] != 8'd0, b[22:0]};
      my = {a[30:23] != 8'd0, a[22:0]};
    end

    dexp = ex - ey;
    xe   = {1'b0, mx, 3'b000};
    yf   = {1'b0, my, 3'b000};
    mask = ~(28'hFFFFFFF << dexp);
    if (dexp > 10'd26) begin
      ys = {27'd0, |my};
    end else begin
      ys = (yf >> dexp) | {27'd0, |(yf & mask)};
    end

    s  = (sx == sy) ? (xe + ys) : (xe - ys);
    er = ex;
    if (s[27]) begin
      s  = {1'b0, s[27:2], s[1] | s[0]};
      er = er + 10'd1;
    end
    for (int i = 0; i < 27; i++) begin
      if (!s[26] && (er > 10'd1)) begin
        s  = {s[26:0], 1'b0};
        er = er - 10'd1;
      end
    end

    rnd = s[2] & (s[1] | s[0] | s[3]);
    m   = {1'b0, s[26:3]} + {24'd0, rnd};
    if (m[24]) begin
      m  = {1'b0, m[24:1]};
      er = er + 10'd1;
    end

    out = {sx, m[23] ? er[7:0] : 8'd0, m[22:0]};
    if (er >= 10'd255) out = {sx, 8'hFF, 23'd0};
    if (s == 28'd0) out = {a[31] & b[31], 31'd0};
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
      out = 32'h7FC00000;
    end else if (a_inf) begin
      out = a;
    end else if (b_inf) begin
      out = b;
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting at rr_ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx
);

  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (enable && !found && req[idx]) begin
        found          = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - shares one FP adder among NUM_REQ requesters, tagged registered result
module fp_add_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDW     = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]      req_sub,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [FP_W-1:0]         rsp_data,
  output logic [IDW-1:0]          rsp_id,
  output logic [CNT_W-1:0]        op_count
);

  logic               can_issue, transfer;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     gnt_idx;
  logic [FP_W-1:0]    op_a, op_b, sum;

  logic               rsp_valid_q, rsp_valid_d;
  logic [FP_W-1:0]    rsp_data_q, rsp_data_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0]   op_count_q, op_count_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;

  assign can_issue = !rsp_valid_q || rsp_ready;

  // rst_n gates the grant so nothing is accepted while reset is held
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .enable    (can_issue && rst_n),
    .grant     (grant),
    .grant_idx (gnt_idx)
  );

  assign req_ready = grant;
  assign transfer  = |(grant & req_valid);

  always_comb begin
    op_a = req_a[op_lsb(32'(gnt_idx)) +: FP_W];
    op_b = req_b[op_lsb(32'(gnt_idx)) +: FP_W];
    op_b[FP_W-1] = op_b[FP_W-1] ^ req_sub[gnt_idx];
  end

  adder u_adder (
    .a   (op_a),
    .b   (op_b),
    .out (sum)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rr_ptr_d    = rr_ptr_q;
    op_count_d  = op_count_q + CNT_W'(rsp_valid_q && rsp_ready);
    if (transfer) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = sum;
      rsp_id_d    = gnt_idx;
      rr_ptr_d    = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      op_count_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      op_count_q  <= op_count_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb/tb_fp_add_arbiter.sv - self-checking bench for fp_add_arbiter
module tb_fp_add_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N-1:0] req_sub;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_data;
  logic [1:0]   rsp_id;
  logic [15:0]  op_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_add_arbiter #(.NUM_REQ(N), .IDW(2), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .op_count  (op_count)
  );

  function automatic logic [31:0] int_to_fp(input int v);
    int mag;
    int p;
    logic [31:0] r;
    if (v == 0) return 32'd0;
    mag = (v < 0) ? -v : v;
    p = 0;
    for (int k = 0; k < 31; k++) if (mag >= (1 << k)) p = k;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p);
    r[22:0]  = 23'((mag << (23 - p)) & 32'h007FFFFF);
    return r;
  endfunction

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_sub[i]        = s;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    req_a = '0;
    req_b = '0;
    req_sub = '0;
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 32'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", rsp_id); end
    checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", op_count); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = '0;
  endtask

  task automatic test_single;
    @(negedge clk);
    set_op(0, 32'h3F800000, 32'h40000000, 1'b0);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_data !== 32'h40400000) begin errors++; $display("FAIL single_data got=%h exp=40400000", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL single_id got=%0d exp=0", rsp_id); end
    checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL single_count_pre got=%0d exp=0", op_count); end
    @(negedge clk); #1;
    checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", op_count); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_subtract;
    @(negedge clk);
    set_op(2, 32'h40400000, 32'h3F800000, 1'b1);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL sub_ready got=%b exp=0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (rsp_data !== 32'h40000000) begin errors++; $display("FAIL sub_data got=%h exp=40000000", rsp_data); end
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL sub_id got=%0d exp=2", rsp_id); end
    @(negedge clk); #1;
    checks++; if (op_count !== 16'd2) begin errors++; $display("FAIL sub_count got=%0d exp=2", op_count); end
  endtask

  task automatic test_all_valid;
    do_reset;
    for (int i = 0; i < N; i++) set_op(i, 32'h3F800000, 32'h3F800000, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 4'(1 << (k % N))) begin errors++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, req_ready, 4'(1 << (k % N))); end
      if (k > 0) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'((k - 1) % N) || rsp_data !== 32'h40000000) begin
          errors++; $display("FAIL rr_rsp k=%0d got=%b/%0d/%h exp=1/%0d/40000000", k, rsp_valid, rsp_id, rsp_data, (k - 1) % N);
        end
      end
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin errors++; $display("FAIL rr_last got=%b/%0d exp=1/1", rsp_valid, rsp_id); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    do_reset;
    for (int i = 0; i < N; i++) set_op(i, int_to_fp(i + 1), int_to_fp(10 * (i + 1)), 1'b0);
    @(negedge clk);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_first got=%b exp=0001", req_ready); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready c=%0d got=%b exp=0000", c, req_ready); end
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== int_to_fp(11)) begin
        errors++; $display("FAIL bp_hold c=%0d got=%b/%0d/%h exp=1/0/%h", c, rsp_valid, rsp_id, rsp_data, int_to_fp(11));
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release got=%b exp=0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== int_to_fp(22)) begin
      errors++; $display("FAIL bp_next got=%b/%0d/%h exp=1/1/%h", rsp_valid, rsp_id, rsp_data, int_to_fp(22));
    end
    checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL bp_count got=%0d exp=1", op_count); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    do_reset;
    for (int i = 0; i < N; i++) set_op(i, int_to_fp(i + 5), int_to_fp(1), 1'b0);
    @(negedge clk);
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = 4'b1101;
    rsp_ready = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || op_count !== 16'd1) begin
      errors++; $display("FAIL mid_pre got=%b/%0d/%0d exp=1/1/1", rsp_valid, rsp_id, op_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 32'd0 || op_count !== 16'd0) begin
      errors++; $display("FAIL mid_async got=%b/%0d/%h/%0d exp=0/0/0/0", rsp_valid, rsp_id, rsp_data, op_count);
    end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready_rst got=%b exp=0000", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_regrant got=%b exp=0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_random;
    bit          pend[N];
    int          va[N];
    int          vb[N];
    bit          vs[N];
    int          rr, g, m_id, m_cnt, idx;
    bit          m_valid, rdy;
    logic [31:0] m_data;
    logic [3:0]  exp_ready;
    do_reset;
    rr = 0; m_valid = 0; m_data = '0; m_id = 0; m_cnt = 0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 99) < 60)) begin
          pend[i] = 1;
          va[i] = int'($urandom_range(0, 1000)) - 500;
          vb[i] = int'($urandom_range(0, 1000)) - 500;
          vs[i] = 1'($urandom_range(0, 1));
          set_op(i, int_to_fp(va[i]), int_to_fp(vb[i]), vs[i]);
        end
        req_valid[i] = pend[i];
      end
      rdy = ($urandom_range(0, 99) < 70);
      rsp_ready = rdy;
      #1;
      checks++; if (rsp_valid !== m_valid || rsp_data !== m_data || rsp_id !== 2'(m_id) || op_count !== 16'(m_cnt)) begin
        errors++; $display("FAIL rand_rsp c=%0d got=%b/%h/%0d/%0d exp=%b/%h/%0d/%0d", c, rsp_valid, rsp_data, rsp_id, op_count, m_valid, m_data, m_id, m_cnt);
      end
      g = -1;
      if (!m_valid || rdy) begin
        for (int k = 0; k < N; k++) begin
          idx = (rr + k) % N;
          if (g < 0 && pend[idx]) g = idx;
        end
      end
      exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready); end
      if (m_valid && rdy) m_cnt++;
      if (g >= 0) begin
        m_data  = int_to_fp(vs[g] ? va[g] - vb[g] : va[g] + vb[g]);
        m_id    = g;
        m_valid = 1;
        rr      = (g + 1) % N;
        pend[g] = 0;
      end else if (rdy) begin
        m_valid = 0;
      end
    end
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_wrap;
    do_reset;
    for (int i = 0; i < N; i++) set_op(i, 32'h3F800000, 32'h3F800000, 1'b0);
    @(negedge clk);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    repeat (65536) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (op_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_max got=%0d exp=65535", op_count); end
    req_valid = '0;
    @(negedge clk); #1;
    checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL wrap_zero got=%0d exp=0", op_count); end
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk); #1;
    checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL wrap_one got=%0d exp=1", op_count); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_subtract;
    test_all_valid;
    test_backpressure;
    test_reset_mid;
    test_random;
    test_wrap;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
